// File: rtl/serial_word_tx.sv
// -----------------------------------------------------------------------------
// serial_word_tx
//
// Transmit end of the serial link. Captures an n-bit word from the game-state
// registers and shifts it out on a single wire as:
//
//   start bit (0) | n data bits, LSB first | stop bit (1)
//
// Each bit is held on tx for CLKS_PER_BIT clock cycles, so a frame lasts
// (n+2)*CLKS_PER_BIT cycles. The line idles high.
//
// Parameters
//   n             data word width in bits (>= 1)
//   CLKS_PER_BIT  clock cycles per bit on tx (>= 1)
//
// Ports
//   clk    in   system clock, all state changes on the rising edge
//   reset  in   synchronous, active-high reset (wins over load and any frame)
//   in     in   word to send, sampled only on the accept edge
//   load   in   send request, accepted on an edge where load && ready
//   ready  out  high only while idle; a word can be accepted
//   tx     out  serial line
//   busy   out  high from the cycle after accept until the frame ends (!ready)
//   done   out  one-cycle pulse in the last cycle of the stop bit
//
// Every output is a flop. The output flops are loaded from the *next* state
// so that they change on the same edge as the state register, rather than
// lagging it by a cycle.
// -----------------------------------------------------------------------------
module serial_word_tx #(
  parameter int n            = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] in,
  input  logic         load,
  output logic         ready,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  // Counter widths. Both are forced to at least one bit so that the
  // degenerate cases (n == 1, CLKS_PER_BIT == 1) still elaborate.
  localparam int BW = (n > 1) ? $clog2(n) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Terminal counts. The bit index never counts past n-1, so BW = clog2(n)
  // is sufficient even when n is a power of two.
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(n - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [n-1:0]   shift_q, shift_d;
  logic [BW-1:0]  bit_q,   bit_d;
  logic [CW-1:0]  baud_q,  baud_d;
  logic           tx_q,    tx_d;
  logic           ready_q, ready_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;

  // High on the final cycle of the current bit period.
  logic baud_wrap;
  assign baud_wrap = (baud_q == BAUD_LAST);

  // ---------------------------------------------------------------------------
  // State register and output flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;

    unique case (state_q)
      IDLE: begin
        // ready_q is high exactly when in IDLE; it is used here so that the
        // accept condition matches what the producer observes on the port.
        if (load && ready_q) begin
          shift_d = in;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end

      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          // The bit on the wire is always shift[0]; consume it at the
          // bit boundary.
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      STOP: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, captured into the output flops.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_d    = 1'b1;
    done_d  = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b1;

    unique case (state_d)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      START: begin
        tx_d = 1'b0;
      end
      DATA: begin
        tx_d = shift_d[0];
      end
      STOP: begin
        tx_d   = 1'b1;
        // Last cycle of the stop bit. With CLKS_PER_BIT == 1 this is the
        // first and only stop cycle.
        done_d = (baud_d == BAUD_LAST);
      end
      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
module tb_serial_word_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       load;
  logic       ready, tx, busy, done;

  logic [3:0] din2;
  logic       load2;
  logic       ready2, tx2, busy2, done2;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  serial_word_tx #(.n(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .in(din), .load(load),
    .ready(ready), .tx(tx), .busy(busy), .done(done)
  );

  serial_word_tx #(.n(4), .CLKS_PER_BIT(1)) dut2 (
    .clk(clk), .reset(reset), .in(din2), .load(load2),
    .ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards are sampled at the next edge
  // and outputs read afterwards are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".tx"},    tx,    1'b1);
    chk({tag, ".ready"}, ready, 1'b1);
    chk({tag, ".busy"},  busy,  1'b0);
    chk({tag, ".done"},  done,  1'b0);
  endtask

  // Called in cycle 1 of a frame (just after the accept edge). Checks all
  // 40 cycles, stepping after each, and ends in the cycle after the frame.
  // If pulse_at > 0, load is pulsed with din=FF in that cycle.
  task automatic run_frame(input logic [7:0] w, input int pulse_at, input string tag);
    logic [9:0] frame;
    logic       exp_bit;
    frame = {1'b1, w, 1'b0};
    for (int j = 1; j <= 40; j++) begin
      exp_bit = frame[(j - 1) / 4];
      chk($sformatf("%s.tx[%0d]", tag, j),   tx,    exp_bit);
      chk($sformatf("%s.done[%0d]", tag, j), done,  (j == 40));
      chk($sformatf("%s.busy[%0d]", tag, j), busy,  1'b1);
      chk($sformatf("%s.rdy[%0d]", tag, j),  ready, 1'b0);
      if (pulse_at > 0 && j == pulse_at) begin
        load = 1'b1;
        din  = 8'hFF;
      end
      if (pulse_at > 0 && j == pulse_at + 1) load = 1'b0;
      step();
    end
    chk_idle({tag, ".end"});
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; din = 8'h00;
    load2 = 1'b0; din2 = 4'h0;

    // Reset then idle
    step(); step();
    chk_idle("reset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_idle($sformatf("idle%0d", i));
    end

    // Reset and load in the same cycle: reset wins
    reset = 1'b1; load = 1'b1; din = 8'hAA;
    step();
    reset = 1'b0; load = 1'b0;
    chk_idle("rst_load");
    step();
    chk_idle("rst_load2");

    // Single frame A5
    din = 8'hA5; load = 1'b1;
    step();
    load = 1'b0;
    run_frame(8'hA5, 0, "a5");

    // Load while busy: frame carries 3C, FF pulse ignored
    step();
    din = 8'h3C; load = 1'b1;
    step();
    load = 1'b0; din = 8'hFF;
    run_frame(8'h3C, 10, "busy");
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle($sformatf("nosecond%0d", i));
    end

    // Back-to-back with load held high
    din = 8'h01; load = 1'b1;
    step();
    din = 8'h80;
    run_frame(8'h01, 0, "b2b1");
    step();
    load = 1'b0;
    run_frame(8'h80, 0, "b2b2");

    // Reset mid-frame
    step();
    din = 8'h00; load = 1'b1;
    step();
    load = 1'b0;
    for (int j = 1; j < 15; j++) begin
      chk($sformatf("mid.tx[%0d]", j), tx, 1'b0);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("midrst");
    for (int i = 0; i < 40; i++) begin
      step();
      chk_idle($sformatf("midrst_idle%0d", i));
    end
    din = 8'hFF; load = 1'b1;
    step();
    load = 1'b0;
    run_frame(8'hFF, 0, "ff");

    // n=4, CLKS_PER_BIT=1: 4'b1001 -> 0,1,0,0,1,1
    begin
      logic [5:0] exp_tx;
      exp_tx = 6'b110010;
      chk("d2.idle_tx", tx2, 1'b1);
      chk("d2.idle_rdy", ready2, 1'b1);
      din2 = 4'b1001; load2 = 1'b1;
      step();
      load2 = 1'b0; din2 = 4'b0110;
      for (int j = 1; j <= 6; j++) begin
        chk($sformatf("d2.tx[%0d]", j),   tx2,    exp_tx[j - 1]);
        chk($sformatf("d2.done[%0d]", j), done2,  (j == 6));
        chk($sformatf("d2.busy[%0d]", j), busy2,  1'b1);
        step();
      end
      chk("d2.end_rdy",  ready2, 1'b1);
      chk("d2.end_tx",   tx2,    1'b1);
      chk("d2.end_done", done2,  1'b0);
      chk("d2.end_busy", busy2,  1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
